cic_decim_comb: RTL and testbench

//  Decimator and comb section of the CIC decimation filter. Sits directly downstream of the cascaded

---
 rtl/cic_pkg.sv | 15 +
 rtl/cic_comb.sv | 37 +++
 rtl/cic_decim_comb.sv | 100 ++++++++++
 tb/tb_cic_decim_comb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared CIC constants (default DW/N/R/M) and the phase-counter width helper,
// used by both the integrator top and the decimating comb top.
package cic_pkg;

   localparam int CIC_DW = 16;
   localparam int CIC_N  = 3;
   localparam int CIC_R  = 8;
   localparam int CIC_M  = 1;

   // Width of a counter that counts 0..r-1; never narrower than one bit.
   function automatic int cic_ph_width(input int r);
      return (r > 2) ? $clog2(r) : 1;
   endfunction

endpackage

// File: rtl/cic_comb.sv
// One registered comb stage y = x - x[z^-M], wrapping modulo 2^DW; latency 1 clk.
// Never stalls: the valid token follows its data and the delay line advances only on a token.
module cic_comb
   import cic_pkg::*;
#(
   parameter int DW = CIC_DW,
   parameter int M  = CIC_M
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   logic [M-1:0][DW-1:0] dly;

   always_ff @(posedge clk) begin
      if (reset) begin
         dly       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            // No growth and no saturation: wrapping is what makes the CIC cancel correctly.
            out_data <= in_data - dly[M-1];
            dly[0]   <= in_data;
            for (int i = 1; i < M; i++) begin
               dly[i] <= dly[i-1];
            end
         end
      end
   end

endmodule

// File: rtl/cic_decim_comb.sv
// CIC decimator + N comb stages; dout_valid rises N+1 clk after the decimating ce edge.
// Never stalls: a new result overwrites an unconsumed dout (sticky overrun with CIC_COMB_OVERRUN_EN).
module cic_decim_comb
   import cic_pkg::*;
#(
   parameter int DW = CIC_DW,
   parameter int N  = CIC_N,
   parameter int R  = CIC_R,
   parameter int M  = CIC_M
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   input  logic          dout_ready
`ifdef CIC_COMB_OVERRUN_EN
   ,
   output logic          overrun
`endif
);

   localparam int            PW      = cic_ph_width(R);
   localparam logic [PW-1:0] PH_LAST = PW'(R - 1);

   logic [PW-1:0] ph;
   logic          cap_valid;
   logic [DW-1:0] cap_data;

   logic          stg_valid [0:N];
   logic [DW-1:0] stg_data  [0:N];

   logic          tok;
   logic          take;

   // Phase counter and decimation capture; only ce moves the phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         ph        <= '0;
         cap_valid <= 1'b0;
         cap_data  <= '0;
      end else begin
         cap_valid <= 1'b0;
         if (ce) begin
            if (ph == PH_LAST) begin
               ph        <= '0;
               cap_valid <= 1'b1;
               cap_data  <= din;
            end else begin
               ph <= ph + 1'b1;
            end
         end
      end
   end

   assign stg_valid[0] = cap_valid;
   assign stg_data[0]  = cap_data;

   for (genvar k = 0; k < N; k++) begin : g_comb
      cic_comb #(
         .DW (DW),
         .M  (M)
      ) u_comb (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (stg_valid[k]),
         .in_data   (stg_data[k]),
         .out_valid (stg_valid[k+1]),
         .out_data  (stg_data[k+1])
      );
   end

   assign tok  = stg_valid[N];
   assign take = dout_valid && dout_ready;

   // A new token always wins; a handshake only empties the register when nothing new arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (tok) begin
         dout       <= stg_data[N];
         dout_valid <= 1'b1;
      end else if (take) begin
         dout_valid <= 1'b0;
      end
   end

`ifdef CIC_COMB_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (tok && dout_valid && !dout_ready) begin
         overrun <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cic_decim_comb.sv
// Bench for cic_decim_comb: an 8-bit N=1 R=4 M=1 instance under directed steps and a 16-bit
// N=3 R=5 M=2 instance with random data/ready, both scored against a reference model queue.
`timescale 1ns/1ps
module tb_cic_decim_comb;

   localparam int DW1 = 8,  N1 = 1, R1 = 4, M1 = 1;
   localparam int DW2 = 16, N2 = 3, R2 = 5, M2 = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic [7:0]  din1;
   logic [7:0]  dout1;
   logic        dout_valid1;
   logic        dout_ready1;
   logic [15:0] din2;
   logic [15:0] dout2;
   logic        dout_valid2;
   logic        dout_ready2;
`ifdef CIC_COMB_OVERRUN_EN
   logic        overrun1;
   logic        overrun2;
   bit          e_ovr1 = 1'b0;
   bit          e_ovr2 = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      int          due;
      logic [15:0] val;
   } tok_t;

   tok_t q1[$];
   tok_t q2[$];

   int          p1 = 0;
   int          p2 = 0;
   logic [7:0]  dl1;
   logic [15:0] dl2 [0:N2-1][0:M2-1];

   logic [7:0]  e_dout1 = '0;
   bit          e_vld1  = 1'b0;
   logic [15:0] e_dout2 = '0;
   bit          e_vld2  = 1'b0;

   always #5 clk = ~clk;

   cic_decim_comb #(.DW(DW1), .N(N1), .R(R1), .M(M1)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .ce         (ce),
      .din        (din1),
      .dout       (dout1),
      .dout_valid (dout_valid1),
      .dout_ready (dout_ready1)
`ifdef CIC_COMB_OVERRUN_EN
      ,
      .overrun    (overrun1)
`endif
   );

   cic_decim_comb #(.DW(DW2), .N(N2), .R(R2), .M(M2)) dut2 (
      .clk        (clk),
      .reset      (reset),
      .ce         (ce),
      .din        (din2),
      .dout       (dout2),
      .dout_valid (dout_valid2),
      .dout_ready (dout_ready2)
`ifdef CIC_COMB_OVERRUN_EN
      ,
      .overrun    (overrun2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one clock of stimulus; the model predicts captures for the upcoming edge.
   task automatic step(input bit c, input logic [7:0] d1, input bit r, input bit rdy1);
      logic [7:0]  x1;
      logic [15:0] x;
      logic [15:0] y;
      reset       = r;
      ce          = c;
      din1        = d1;
      din2        = 16'($urandom);
      dout_ready1 = rdy1;
      dout_ready2 = ($urandom_range(0, 3) != 0);
      if (r) begin
         p1  = 0;
         p2  = 0;
         dl1 = '0;
         for (int k = 0; k < N2; k++)
            for (int m = 0; m < M2; m++)
               dl2[k][m] = '0;
      end else if (c) begin
         if (p1 == R1 - 1) begin
            x1  = d1 - dl1;
            dl1 = d1;
            q1.push_back('{cyc + N1 + 2, {8'h00, x1}});
            p1 = 0;
         end else begin
            p1++;
         end
         if (p2 == R2 - 1) begin
            x = din2;
            for (int k = 0; k < N2; k++) begin
               y = x - dl2[k][M2-1];
               for (int m = M2 - 1; m > 0; m--) dl2[k][m] = dl2[k][m-1];
               dl2[k][0] = x;
               x = y;
            end
            q2.push_back('{cyc + N2 + 2, x});
            p2 = 0;
         end else begin
            p2++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input bit rdy);
      repeat (n) step(1'b0, 8'($urandom), 1'b0, rdy);
   endtask

   task automatic feed(input logic [7:0] v, input bit rdy);
      repeat (R1 - 1) step(1'b1, 8'($urandom), 1'b0, rdy);
      step(1'b1, v, 1'b0, rdy);
   endtask

   // Compare the output registers, then advance the expected register state across the next edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("vld1",  32'(dout_valid1), 32'(e_vld1));
         chk("dout1", 32'(dout1),       32'(e_dout1));
         chk("vld2",  32'(dout_valid2), 32'(e_vld2));
         chk("dout2", 32'(dout2),       32'(e_dout2));
`ifdef CIC_COMB_OVERRUN_EN
         chk("ovr1", 32'(overrun1), 32'(e_ovr1));
         chk("ovr2", 32'(overrun2), 32'(e_ovr2));
`endif
         if (reset) begin
            e_dout1 = '0; e_vld1 = 1'b0;
            e_dout2 = '0; e_vld2 = 1'b0;
`ifdef CIC_COMB_OVERRUN_EN
            e_ovr1 = 1'b0; e_ovr2 = 1'b0;
`endif
            q1.delete();
            q2.delete();
         end else begin
            if (q1.size() > 0 && q1[0].due == cyc + 1) begin
`ifdef CIC_COMB_OVERRUN_EN
               if (e_vld1 && !dout_ready1) e_ovr1 = 1'b1;
`endif
               e_dout1 = q1[0].val[7:0];
               e_vld1  = 1'b1;
               void'(q1.pop_front());
            end else if (e_vld1 && dout_ready1) begin
               e_vld1 = 1'b0;
            end
            if (q2.size() > 0 && q2[0].due == cyc + 1) begin
`ifdef CIC_COMB_OVERRUN_EN
               if (e_vld2 && !dout_ready2) e_ovr2 = 1'b1;
`endif
               e_dout2 = q2[0].val;
               e_vld2  = 1'b1;
               void'(q2.pop_front());
            end else if (e_vld2 && dout_ready2) begin
               e_vld2 = 1'b0;
            end
         end
      end
   end

   initial begin
      reset = 1'b1; ce = 1'b0; din1 = '0; din2 = '0;
      dout_ready1 = 1'b1; dout_ready2 = 1'b1;
      step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      mon_en = 1'b1;
      chk("rst_ph",   32'(dut1.ph),     32'd0);
      chk("rst_dout", 32'(dout1),       32'd0);
      chk("rst_vld",  32'(dout_valid1), 32'd0);

      // Basic decimation: din = 1,2,3,... every clk; captures 4, 8, 12 all give 4.
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
      step(1'b1, 8'd5, 1'b0, 1'b1);
      chk("lat_e1_vld", 32'(dout_valid1), 32'd0);
      step(1'b1, 8'd6, 1'b0, 1'b1);
      chk("lat_e2_vld",  32'(dout_valid1), 32'd1);
      chk("lat_e2_dout", 32'(dout1),       32'd4);
      step(1'b1, 8'd7, 1'b0, 1'b1);
      chk("lat_e3_vld", 32'(dout_valid1), 32'd0);
      for (int i = 8; i <= 12; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
      idle(4, 1'b1);
      chk("basic_dout", 32'(dout1), 32'd4);

      // Reset mid-stream (ce kept high) clears everything.
      step(1'b1, 8'd1, 1'b0, 1'b1);
      step(1'b1, 8'd2, 1'b0, 1'b1);
      step(1'b1, 8'd3, 1'b1, 1'b1);
      step(1'b1, 8'd4, 1'b1, 1'b1);
      chk("mid_rst_ph",   32'(dut1.ph),     32'd0);
      chk("mid_rst_dout", 32'(dout1),       32'd0);
      chk("mid_rst_vld",  32'(dout_valid1), 32'd0);

      // ce one clk in three: phase follows ce, not clk.
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b1);
         step(1'b0, 8'($urandom), 1'b0, 1'b1);
         step(1'b0, 8'($urandom), 1'b0, 1'b1);
         if (i == 3) chk("gap_ph3", 32'(dut1.ph), 32'd3);
      end
      idle(4, 1'b1);
      chk("gap_dout", 32'(dout1), 32'd4);

      // Wrap-around: 120 then -120 must give 16, not a saturated value.
      step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      feed(8'd120, 1'b1);
      idle(3, 1'b1);
      chk("wrap_first", 32'(dout1), 32'd120);
      feed(8'h88, 1'b1);
      idle(3, 1'b1);
      chk("wrap_dout", 32'(dout1), 32'h10);

      // Handshake in the same clk as a new token: sample loads, valid stays high.
      feed(8'd50, 1'b0);
      idle(3, 1'b0);
      chk("col_hold_vld",  32'(dout_valid1), 32'd1);
      chk("col_hold_dout", 32'(dout1),       32'd170);
      feed(8'd70, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("col_vld",  32'(dout_valid1), 32'd1);
      chk("col_dout", 32'(dout1),       32'd20);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("col_drop_vld", 32'(dout_valid1), 32'd0);
`ifdef CIC_COMB_OVERRUN_EN
      chk("col_no_ovr", 32'(overrun1), 32'd0);
`endif

      // Backpressure across two results: the second overwrites the first.
      feed(8'd10, 1'b0);
      idle(3, 1'b0);
      chk("bp_first", 32'(dout1), 32'd196);
      feed(8'd40, 1'b0);
      idle(3, 1'b0);
      chk("bp_vld",  32'(dout_valid1), 32'd1);
      chk("bp_dout", 32'(dout1),       32'd30);
`ifdef CIC_COMB_OVERRUN_EN
      chk("bp_ovr", 32'(overrun1), 32'd1);
`endif
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("bp_drain_vld", 32'(dout_valid1), 32'd0);
`ifdef CIC_COMB_OVERRUN_EN
      chk("bp_ovr_sticky", 32'(overrun1), 32'd1);
`endif

      // Let the random instance finish its in-flight results, then reset once more.
      idle(12, 1'b1);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("end_rst_vld", 32'(dout_valid1), 32'd0);
`ifdef CIC_COMB_OVERRUN_EN
      chk("end_rst_ovr", 32'(overrun1), 32'd0);
`endif
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
